// File: rtl/spi_slave_param.sv
// Parameterised SPI slave sampled by the system clock: any CPOL/CPHA, MSB-first words,
// TX holding register with underrun detection, RX overrun strobe and per-frame word count.
module spi_slave_param #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      CPOL        = 0,
   parameter int unsigned      CPHA        = 0,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sck,
   input  logic             ssel_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             overrun,
   input  logic             rx_ready,
   output logic             underrun,
   output logic             frame_active,
   output logic             frame_end,
   output logic [7:0]       word_count
);
   localparam int unsigned SL  = SYNC_STAGES + 1;
   localparam int unsigned BCW = $clog2(WIDTH);
   localparam logic        POL = (CPOL != 0);
   localparam logic        PHA = (CPHA != 0);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   logic [SL-1:0]          sck_q, ssel_q, settle_q;
   logic [SYNC_STAGES-1:0] mosi_q;

   state_t                 state_q, state_d;
   logic                   armed_q, armed_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                   load_pend_q, load_pend_d;
   logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0]       rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   ack_pend_q, ack_pend_d;
   logic                   underrun_q, underrun_d;
   logic                   frame_end_q, frame_end_d;
   logic [7:0]             wc_q, wc_d;
   logic [WIDTH-1:0]       hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;

   logic sck_s, sck_p, sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e;
   logic ssel_s, ssel_rise, ssel_fall, mosi_s, load;
   logic [WIDTH-1:0] rx_word;

   // The tap after the synchroniser is one extra delay flop used only for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q    <= {SL{POL}};
         ssel_q   <= '1;
         mosi_q   <= '0;
         settle_q <= '0;
      end else begin
         sck_q    <= {sck_q[SL-2:0], sck};
         ssel_q   <= {ssel_q[SL-2:0], ssel_n};
         mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
         settle_q <= {settle_q[SL-2:0], 1'b1};
      end
   end

   assign sck_s     = sck_q[SL-2];
   assign sck_p     = sck_q[SL-1];
   assign sck_rise  = sck_s & ~sck_p;
   assign sck_fall  = ~sck_s & sck_p;
   assign lead_e    = POL ? sck_fall : sck_rise;
   assign trail_e   = POL ? sck_rise : sck_fall;
   assign sample_e  = PHA ? trail_e : lead_e;
   assign shift_e   = PHA ? lead_e : trail_e;
   assign ssel_s    = ssel_q[SL-2];
   assign ssel_rise = ssel_s & ~ssel_q[SL-1];
   assign ssel_fall = ~ssel_s & ssel_q[SL-1];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];
   assign rx_word   = {rx_sh_q[WIDTH-2:0], mosi_s};

   always_comb begin
      state_d     = state_q;
      // Arming waits until the synchroniser holds real samples, not its reset preset.
      armed_d     = armed_q | (settle_q[SL-1] & ssel_s);
      bit_cnt_d   = bit_cnt_q;
      load_pend_d = load_pend_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      overrun_d   = 1'b0;
      underrun_d  = 1'b0;
      frame_end_d = 1'b0;
      ack_pend_d  = ack_pend_q & ~rx_ready;
      wc_d        = wc_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ssel_fall && armed_q) begin
               state_d     = S_ACTIVE;
               wc_d        = '0;
               bit_cnt_d   = '0;
               load_pend_d = PHA;
               load        = ~PHA;
            end
         end
         S_ACTIVE: begin
            if (sample_e) begin
               rx_sh_d = rx_word;
               if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                  bit_cnt_d   = '0;
                  rx_data_d   = rx_word;
                  rx_valid_d  = 1'b1;
                  overrun_d   = ack_pend_q & ~rx_ready;
                  ack_pend_d  = 1'b1;
                  load_pend_d = 1'b1;
                  if (wc_q != 8'hFF) wc_d = wc_q + 8'd1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
            if (shift_e) begin
               if (load_pend_q) begin
                  load        = 1'b1;
                  load_pend_d = 1'b0;
               end else begin
                  tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
               end
            end
            // A word completing in the same clk as deselect is delivered before the frame closes.
            if (ssel_rise) begin
               state_d     = S_IDLE;
               frame_end_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         if (hold_full_q) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_sh_d    = IDLE_WORD;
            underrun_d = (state_q == S_ACTIVE);
         end
      end
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         load_pend_q <= 1'b0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         ack_pend_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_end_q <= 1'b0;
         wc_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         load_pend_q <= load_pend_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         ack_pend_q  <= ack_pend_d;
         underrun_q  <= underrun_d;
         frame_end_q <= frame_end_d;
         wc_q        <= wc_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign miso         = (state_q == S_ACTIVE) & tx_sh_q[WIDTH-1];
   assign miso_oe      = (state_q == S_ACTIVE);
   assign frame_active = (state_q == S_ACTIVE);
   assign tx_ready     = ~hold_full_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign overrun      = overrun_q;
   assign underrun     = underrun_q;
   assign frame_end    = frame_end_q;
   assign word_count   = wc_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: two 8-bit slaves (mode 0, mode 1) and four 16-bit slaves (modes 0-3),
// each driven by its own SPI master pins; received words are scoreboarded against a queue.
module tb_spi_slave_param;
   localparam int HALF = 8;
   localparam int SL   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  sck = 6'b110000;
   logic [5:0]  ssel_n = '1;
   logic [5:0]  mosi = '0;
   logic [5:0]  tx_valid = '0;
   logic [5:0]  rx_ready = '1;
   logic [15:0] tx_data [6] = '{default: 16'h0000};

   wire [5:0]  miso, miso_oe, tx_ready, rx_valid, overrun, underrun, frame_active, frame_end;
   wire [15:0] rx_data [6];
   wire [7:0]  word_count [6];

   int checks = 0;
   int errors = 0;
   int cur = 0;
   logic [16:0] exp_q [$];
   int rv_cnt [6] = '{default: 0};
   int ur_cnt [6] = '{default: 0};
   int fe_cnt [6] = '{default: 0};
   int fa_cnt [6] = '{default: 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_w8
      wire [7:0] rxd;
      spi_slave_param #(.WIDTH(8), .CPOL(0), .CPHA(g), .SYNC_STAGES(2), .IDLE_WORD(8'h5C)) dut (
         .clk(clk), .rst_n(rst_n), .sck(sck[g]), .ssel_n(ssel_n[g]), .mosi(mosi[g]),
         .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data[g][7:0]), .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]), .rx_data(rxd), .rx_valid(rx_valid[g]), .overrun(overrun[g]),
         .rx_ready(rx_ready[g]), .underrun(underrun[g]), .frame_active(frame_active[g]),
         .frame_end(frame_end[g]), .word_count(word_count[g]));
      assign rx_data[g] = {8'h00, rxd};
   end

   for (genvar g = 0; g < 4; g++) begin : g_w16
      spi_slave_param #(.WIDTH(16), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .IDLE_WORD(16'hD00D)) dut (
         .clk(clk), .rst_n(rst_n), .sck(sck[g+2]), .ssel_n(ssel_n[g+2]), .mosi(mosi[g+2]),
         .miso(miso[g+2]), .miso_oe(miso_oe[g+2]), .tx_data(tx_data[g+2]), .tx_valid(tx_valid[g+2]),
         .tx_ready(tx_ready[g+2]), .rx_data(rx_data[g+2]), .rx_valid(rx_valid[g+2]), .overrun(overrun[g+2]),
         .rx_ready(rx_ready[g+2]), .underrun(underrun[g+2]), .frame_active(frame_active[g+2]),
         .frame_end(frame_end[g+2]), .word_count(word_count[g+2]));
   end

   // Scoreboard: every rx_valid must match the next expected {overrun, word} of the slave under test.
   always @(negedge clk) begin
      logic [16:0] e;
      if (rst_n) begin
         for (int i = 0; i < 6; i++) begin
            if (frame_end[i]) fe_cnt[i]++;
            if (underrun[i]) ur_cnt[i]++;
            if (frame_active[i] || miso_oe[i]) fa_cnt[i]++;
            if (rx_valid[i]) begin
               rv_cnt[i]++;
               checks++;
               if (i != cur || exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rx_unexpected: dut %0d gave rx_data=%h overrun=%b, none expected", i, rx_data[i], overrun[i]);
               end else begin
                  e = exp_q.pop_front();
                  if ({overrun[i], rx_data[i]} !== e) begin
                     errors++;
                     $display("FAIL rx_word: dut %0d got overrun=%b data=%h, expected overrun=%b data=%h",
                              i, overrun[i], rx_data[i], e[16], e[15:0]);
                  end
               end
            end else if (overrun[i]) begin
               checks++;
               errors++;
               $display("FAIL overrun_alone: dut %0d overrun=1 with rx_valid=0, expected 0", i);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic pol_of(input int idx);
      return idx >= 4;
   endfunction

   function automatic logic pha_of(input int idx);
      return (idx % 2) == 1;
   endfunction

   function automatic int width_of(input int idx);
      return (idx < 2) ? 8 : 16;
   endfunction

   task automatic preload(input int idx, input logic [15:0] d);
      tx_data[idx]  = d;
      tx_valid[idx] = 1'b1;
      for (int n = 0; n < 20 && tx_ready[idx]; n++) clks(1);
      tx_valid[idx] = 1'b0;
      checks++;
      if (tx_ready[idx] !== 1'b0) begin
         errors++;
         $display("FAIL preload: dut %0d tx_ready=%b after capture, expected 0", idx, tx_ready[idx]);
      end
   endtask

   task automatic sel(input int idx);
      ssel_n[idx] = 1'b0;
      clks(HALF);
   endtask

   task automatic desel(input int idx);
      clks(HALF);
      ssel_n[idx] = 1'b1;
      clks(HALF);
   endtask

   // Master shifts nbits of mo MSB first and samples MISO on its sample edge.
   task automatic xfer(input int idx, input int nbits, input logic [15:0] mo, input bit end_last,
                       output logic [15:0] mi);
      int w;
      logic pol, pha;
      w   = width_of(idx);
      pol = pol_of(idx);
      pha = pha_of(idx);
      mi  = '0;
      for (int k = 0; k < nbits; k++) begin
         int b;
         b = w - 1 - k;
         if (!pha) begin
            mosi[idx] = mo[b];
            clks(HALF);
            mi[b] = miso[idx];
            sck[idx] = ~pol;
            clks(HALF);
            sck[idx] = pol;
         end else begin
            sck[idx]  = ~pol;
            mosi[idx] = mo[b];
            clks(HALF);
            mi[b] = miso[idx];
            sck[idx] = pol;
            if (end_last && k == nbits - 1) ssel_n[idx] = 1'b1;
            clks(HALF);
         end
      end
   endtask

   task automatic test_reset;
      clks(3);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({miso[i], miso_oe[i], frame_active[i], tx_ready[i], rx_valid[i], overrun[i], underrun[i], frame_end[i]} !== 8'b0001_0000) begin
            errors++;
            $display("FAIL reset_flags: dut %0d got %b, expected 00010000", i,
                     {miso[i], miso_oe[i], frame_active[i], tx_ready[i], rx_valid[i], overrun[i], underrun[i], frame_end[i]});
         end
         checks++;
         if (rx_data[i] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rx_data: dut %0d got %h, expected 0000", i, rx_data[i]);
         end
         checks++;
         if (word_count[i] !== 8'd0) begin
            errors++;
            $display("FAIL reset_word_count: dut %0d got %0d, expected 0", i, word_count[i]);
         end
      end
      rst_n = 1'b1;
      clks(SL + 4);
   endtask

   task automatic test_basic_mode0;
      logic [15:0] mi;
      int rv0, fe0;
      cur = 0;
      preload(0, 16'h00A5);
      rv0 = rv_cnt[0];
      fe0 = fe_cnt[0];
      exp_q.push_back({1'b0, 16'h003C});
      sel(0);
      checks++;
      if ({frame_active[0], miso_oe[0]} !== 2'b11) begin
         errors++;
         $display("FAIL basic_active: frame_active/miso_oe=%b, expected 11", {frame_active[0], miso_oe[0]});
      end
      xfer(0, 8, 16'h003C, 1'b0, mi);
      checks++;
      if (mi !== 16'h00A5) begin
         errors++;
         $display("FAIL basic_miso: master got %h, expected 00a5", mi);
      end
      checks++;
      if (tx_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL basic_tx_ready: got %b, expected 1", tx_ready[0]);
      end
      desel(0);
      checks++;
      if (rv_cnt[0] - rv0 != 1 || fe_cnt[0] - fe0 != 1) begin
         errors++;
         $display("FAIL basic_strobes: rx_valid x%0d frame_end x%0d, expected 1 and 1", rv_cnt[0] - rv0, fe_cnt[0] - fe0);
      end
      checks++;
      if (word_count[0] !== 8'd1 || rx_data[0] !== 16'h003C || frame_active[0] !== 1'b0) begin
         errors++;
         $display("FAIL basic_final: word_count=%0d rx_data=%h frame_active=%b, expected 1 003c 0",
                  word_count[0], rx_data[0], frame_active[0]);
      end
   endtask

   task automatic test_modes16;
      logic [15:0] mi;
      for (int idx = 2; idx < 6; idx++) begin
         cur = idx;
         preload(idx, 16'h1234);
         exp_q.push_back({1'b0, 16'hBEEF});
         sel(idx);
         xfer(idx, 16, 16'hBEEF, 1'b0, mi);
         checks++;
         if (mi !== 16'h1234) begin
            errors++;
            $display("FAIL mode_miso: dut %0d master got %h, expected 1234", idx, mi);
         end
         desel(idx);
         checks++;
         if (word_count[idx] !== 8'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mode_rx: dut %0d word_count=%0d pending=%0d, expected 1 and 0", idx, word_count[idx], exp_q.size());
         end
      end
   endtask

   task automatic test_underrun;
      logic [15:0] mi;
      logic [15:0] want;
      int u0;
      cur = 1;
      preload(1, 16'h0096);
      u0 = ur_cnt[1];
      sel(1);
      for (int w = 0; w < 3; w++) begin
         exp_q.push_back({1'b0, 16'(8'h01 + w)});
         xfer(1, 8, 16'(8'h01 + w), 1'b0, mi);
         want = (w == 0) ? 16'h0096 : 16'h005C;
         checks++;
         if (mi !== want) begin
            errors++;
            $display("FAIL underrun_miso: word %0d master got %h, expected %h", w, mi, want);
         end
         checks++;
         if (tx_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL underrun_tx_ready: word %0d tx_ready=%b, expected 1", w, tx_ready[1]);
         end
      end
      desel(1);
      checks++;
      if (ur_cnt[1] - u0 != 2 || word_count[1] !== 8'd3) begin
         errors++;
         $display("FAIL underrun_count: underrun x%0d word_count=%0d, expected 2 and 3", ur_cnt[1] - u0, word_count[1]);
      end
   endtask

   task automatic test_overrun;
      logic [15:0] mi;
      cur = 0;
      rx_ready[0] = 1'b0;
      exp_q.push_back({1'b0, 16'h0011});
      exp_q.push_back({1'b1, 16'h0022});
      sel(0);
      xfer(0, 8, 16'h0011, 1'b0, mi);
      xfer(0, 8, 16'h0022, 1'b0, mi);
      desel(0);
      rx_ready[0] = 1'b1;
      checks++;
      if (rx_data[0] !== 16'h0022 || word_count[0] !== 8'd2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL overrun_final: rx_data=%h word_count=%0d pending=%0d, expected 0022 2 0",
                  rx_data[0], word_count[0], exp_q.size());
      end
      clks(2);
   endtask

   task automatic test_abort;
      logic [15:0] mi;
      int rv0, fe0;
      cur = 0;
      rv0 = rv_cnt[0];
      fe0 = fe_cnt[0];
      sel(0);
      xfer(0, 5, 16'h00F8, 1'b0, mi);
      desel(0);
      checks++;
      if (rv_cnt[0] != rv0 || word_count[0] !== 8'd0 || fe_cnt[0] - fe0 != 1) begin
         errors++;
         $display("FAIL abort_partial: rx_valid x%0d word_count=%0d frame_end x%0d, expected 0 0 1",
                  rv_cnt[0] - rv0, word_count[0], fe_cnt[0] - fe0);
      end
      exp_q.push_back({1'b0, 16'h007E});
      sel(0);
      xfer(0, 8, 16'h007E, 1'b0, mi);
      desel(0);
      checks++;
      if (rx_data[0] !== 16'h007E || word_count[0] !== 8'd1) begin
         errors++;
         $display("FAIL abort_next: rx_data=%h word_count=%0d, expected 007e 1", rx_data[0], word_count[0]);
      end
   endtask

   task automatic test_reset_midframe;
      logic [15:0] mi;
      int fa0, rv0;
      cur = 0;
      sel(0);
      xfer(0, 3, 16'h00E0, 1'b0, mi);
      rst_n = 1'b0;
      clks(2);
      checks++;
      if ({frame_active[0], miso_oe[0], miso[0]} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_in_reset: frame_active/miso_oe/miso=%b, expected 000", {frame_active[0], miso_oe[0], miso[0]});
      end
      rst_n = 1'b1;
      fa0 = fa_cnt[0];
      rv0 = rv_cnt[0];
      clks(SL + 2);
      xfer(0, 8, 16'h00FF, 1'b0, mi);
      clks(HALF);
      checks++;
      if (fa_cnt[0] != fa0 || rv_cnt[0] != rv0) begin
         errors++;
         $display("FAIL rst_mid_ignored: active cycles=%0d rx_valid x%0d, expected 0 and 0", fa_cnt[0] - fa0, rv_cnt[0] - rv0);
      end
      ssel_n[0] = 1'b1;
      clks(HALF);
      preload(0, 16'h00C3);
      exp_q.push_back({1'b0, 16'h005A});
      sel(0);
      xfer(0, 8, 16'h005A, 1'b0, mi);
      checks++;
      if (mi !== 16'h00C3) begin
         errors++;
         $display("FAIL rst_mid_miso: master got %h, expected 00c3", mi);
      end
      desel(0);
      checks++;
      if (rx_data[0] !== 16'h005A || word_count[0] !== 8'd1) begin
         errors++;
         $display("FAIL rst_mid_next: rx_data=%h word_count=%0d, expected 005a 1", rx_data[0], word_count[0]);
      end
   endtask

   task automatic test_end_on_last;
      logic [15:0] mi;
      int rv0, fe0;
      cur = 1;
      rv0 = rv_cnt[1];
      fe0 = fe_cnt[1];
      exp_q.push_back({1'b0, 16'h00A7});
      sel(1);
      xfer(1, 8, 16'h00A7, 1'b1, mi);
      clks(HALF);
      checks++;
      if (rv_cnt[1] - rv0 != 1 || fe_cnt[1] - fe0 != 1 || word_count[1] !== 8'd1 || frame_active[1] !== 1'b0) begin
         errors++;
         $display("FAIL end_on_last: rx_valid x%0d frame_end x%0d word_count=%0d frame_active=%b, expected 1 1 1 0",
                  rv_cnt[1] - rv0, fe_cnt[1] - fe0, word_count[1], frame_active[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_mode0();
      test_modes16();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_midframe();
      test_end_on_last();
      clks(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected words never received, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
